bus_arbiter_2m: RTL and testbench
=================================

BUS_ARBITER_2M -- requirements
Module: bus_arbiter_2m

Interface
Parameters:
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin arbitration, 1 = m0 always wins.
REQ-002 The block SHALL have parameter LOCK_MAX, default 16: the maximum number of consecutive cycles m1 may hold the grant with m1_lock while m0 is requesting; legal range 1..255.

Ports (name  direction  width  meaning; m{0,1} = one port per master):
REQ-003 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 m{0,1}_wr  input  1  write request.
REQ-006 m{0,1}_waddr  input  32  write byte address.
REQ-007 m{0,1}_wdata  input  32  write data.
REQ-008 m{0,1}_wstrb  input  4  write byte enables.
REQ-009 m{0,1}_rd  input  1  read request.
REQ-010 m{0,1}_raddr  input  32  read byte address.
REQ-011 m{0,1}_rdata  output  32  read data, valid one cycle after the read is accepted.
REQ-012 m{0,1}_stall  output  1  request not accepted this cycle; the master SHALL hold all request signals stable.
REQ-013 m1_lock  input  1  m1 requests to keep the grant on consecutive cycles (loader burst).
REQ-014 s_wr, s_rd  output  1 each  slave-side write and read enables.
REQ-015 s_waddr, s_raddr  output  32 each  slave-side addresses.
REQ-016 s_wdata  output  32  slave-side write data.
REQ-017 s_wstrb  output  4  slave-side write byte enables.
REQ-018 s_rdata  input  32  slave read data, one cycle after s_rd.

Function
REQ-019 A master's request SHALL be req_i = mi_wr | mi_rd; exactly zero or one master SHALL be granted per cycle, decided combinationally.
REQ-020 The granted master's read and write fields SHALL all pass to s_*; it MAY assert rd and wr in the same cycle, and both SHALL be forwarded.
REQ-021 With no grant, all s_* outputs SHALL be 0.
REQ-022 A master that requests and is not granted SHALL see mi_stall=1. A non-requesting master SHALL see mi_stall=0, and the granted master SHALL see mi_stall=0.
REQ-023 If only one master requests, it SHALL be granted.
REQ-024 If both request and FIXED_PRIO=1, m0 SHALL be granted.
REQ-025 If both request and FIXED_PRIO=0, the master not recorded in last_grant SHALL be granted.
REQ-026 Register last_grant SHALL update to the granted master on every cycle with a grant; it SHALL hold when idle.
REQ-027 Lock: if m1 was granted last cycle with m1_lock=1 and still requests, m1 SHALL win regardless of m0, unless lock_cnt has reached LOCK_MAX.
REQ-028 lock_cnt SHALL be 8 bits. It SHALL increment on each locked m1 grant while m0 requests, and clear when m1 is not granted or m1_lock=0. When lock_cnt reaches LOCK_MAX, the next contended cycle SHALL go to m0.
REQ-029 Read return: register rd_owner (2-bit one-hot {m1,m0}) SHALL capture {grant1&m1_rd, grant0&m0_rd} each cycle. In the next cycle, s_rdata SHALL be routed to the owner's rdata; the other master's rdata SHALL be 0.
REQ-030 The read-return path SHALL never stall: a new grant in the cycle of a return SHALL proceed, giving a 1-cycle read latency and full back-to-back throughput.
REQ-031 Writes SHALL complete in the grant cycle; there SHALL be no write response.

Reset
REQ-032 While rstn=0: last_grant=m1 (so m0 wins the first tie), lock_cnt=0, rd_owner=00; s_wr=s_rd=0, all s_* buses 0, m0_stall=m1_stall=1, m0_rdata=m1_rdata=0.
REQ-033 A read accepted in the cycle before reset assertion SHALL have its return discarded (rd_owner cleared asynchronously).
REQ-034 The first grant SHALL be possible in the first clk edge after rstn deasserts.

Verification
REQ-035 Only m0 reads 0x0100_0010 -> s_rd=1, s_raddr=0x0100_0010, m0_stall=0; next cycle with s_rdata=0xDEADBEEF -> m0_rdata=0xDEADBEEF, m1_rdata=0.
REQ-036 Both masters request continuously for 6 cycles (FIXED_PRIO=0) after reset -> grant order m0,m1,m0,m1,m0,m1; each stall=1 on alternate cycles.
REQ-037 FIXED_PRIO=1 with both requesting for 4 cycles -> m0 granted all 4; m1_stall=1 throughout.
REQ-038 m1_lock=1 and both requesting, LOCK_MAX=4 -> m1 granted 4 consecutive locked cycles after its initial grant, then m0 granted; lock_cnt returns to 0.
REQ-039 m0 write (wstrb=0011) and m0 read in the same cycle, m1 idle -> s_wr=s_rd=1 with the respective addresses; read data is returned to m0 next cycle.
REQ-040 rstn asserted one cycle after an m1 read is accepted -> m1_rdata=0, stalls=1, and s_* outputs are 0 during reset; after release, m0 wins the first tie.

Source files
------------

// File: rtl/bus_arbiter_2m.sv
// ============================================================================
// Module      : bus_arbiter_2m
// Description : Two-master to one-slave bus arbiter. Round-robin or fixed
//               priority arbitration, a bounded m1 lock for loader bursts,
//               and a one-cycle read-return router back to the reading master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_2m #(
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    // master 0
    input  logic        m0_wr,
    input  logic [31:0] m0_waddr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    input  logic        m0_rd,
    input  logic [31:0] m0_raddr,
    output logic [31:0] m0_rdata,
    output logic        m0_stall,
    // master 1
    input  logic        m1_wr,
    input  logic [31:0] m1_waddr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    input  logic        m1_rd,
    input  logic [31:0] m1_raddr,
    output logic [31:0] m1_rdata,
    output logic        m1_stall,
    input  logic        m1_lock,
    // slave
    output logic        s_wr,
    output logic        s_rd,
    output logic [31:0] s_waddr,
    output logic [31:0] s_raddr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata
);

    localparam logic [7:0] c_LOCK_MAX = 8'(LOCK_MAX);
    localparam logic       c_FIXED    = (FIXED_PRIO != 0);

    logic       w_req0;
    logic       w_req1;
    logic       w_lock_win;
    logic       w_grant0;
    logic       w_grant1;

    logic       r_last_grant;   // 0 = m0, 1 = m1
    logic       r_lock_prev;    // m1 held the grant with m1_lock last cycle
    logic [7:0] r_lock_cnt;
    logic [1:0] r_rd_owner;     // one-hot {m1, m0}

    // Grant decision: lock override first, then contention policy, then sole requester
    always_comb begin
        w_req0     = m0_wr | m0_rd;
        w_req1     = m1_wr | m1_rd;
        w_lock_win = r_lock_prev & w_req1 & (r_lock_cnt < c_LOCK_MAX);
        w_grant0   = 1'b0;
        w_grant1   = 1'b0;
        if (rstn) begin
            if (w_lock_win) begin
                w_grant1 = 1'b1;
            end else if (w_req0 && w_req1) begin
                // m0 wins a tie under fixed priority, or when m1 was served last
                if (c_FIXED || r_last_grant) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else if (w_req0) begin
                w_grant0 = 1'b1;
            end else if (w_req1) begin
                w_grant1 = 1'b1;
            end
        end
    end

    // Forward the granted master's fields to the slave, zero when idle
    always_comb begin
        s_wr    = (w_grant0 & m0_wr) | (w_grant1 & m1_wr);
        s_rd    = (w_grant0 & m0_rd) | (w_grant1 & m1_rd);
        s_waddr = '0;
        s_raddr = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (w_grant0) begin
            s_waddr = m0_waddr;
            s_raddr = m0_raddr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (w_grant1) begin
            s_waddr = m1_waddr;
            s_raddr = m1_raddr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
    end

    // Stall losers (everyone during reset); route read data to last cycle's reader
    always_comb begin
        m0_stall = ~rstn | (w_req0 & ~w_grant0);
        m1_stall = ~rstn | (w_req1 & ~w_grant1);
        m0_rdata = r_rd_owner[0] ? s_rdata : '0;
        m1_rdata = r_rd_owner[1] ? s_rdata : '0;
    end

    // Remember who was served last; idle cycles keep the previous owner
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= 1'b1;
        end else if (w_grant0) begin
            r_last_grant <= 1'b0;
        end else if (w_grant1) begin
            r_last_grant <= 1'b1;
        end
    end

    // Track the m1 lock and count locked grants taken while m0 is waiting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock_prev <= 1'b0;
            r_lock_cnt  <= 8'd0;
        end else begin
            r_lock_prev <= w_grant1 & m1_lock;
            if (!w_grant1 || !m1_lock) begin
                r_lock_cnt <= 8'd0;
            end else if (w_lock_win && w_req0 && (r_lock_cnt != 8'hFF)) begin
                r_lock_cnt <= r_lock_cnt + 8'd1;
            end
        end
    end

    // Capture which master's read was accepted; cleared at once by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_owner <= 2'b00;
        end else begin
            r_rd_owner <= {w_grant1 & m1_rd, w_grant0 & m0_rd};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
// ============================================================================
// Module      : tb_bus_arbiter_2m
// Description : Scoreboard bench for bus_arbiter_2m. Two instances share the
//               stimulus: round-robin (LOCK_MAX=4) and fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_2m;

    localparam logic [31:0] M0_WA = 32'h0000_0A00;
    localparam logic [31:0] M0_WD = 32'h1111_0000;
    localparam logic [3:0]  M0_WS = 4'b0011;
    localparam logic [31:0] M0_RA = 32'h0100_0010;
    localparam logic [31:0] M1_WA = 32'h0000_0B00;
    localparam logic [31:0] M1_WD = 32'h2222_0000;
    localparam logic [3:0]  M1_WS = 4'b1111;
    localparam logic [31:0] M1_RA = 32'h0200_0020;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_wr, m0_rd, m1_wr, m1_rd, m1_lock;
    logic [31:0] m0_waddr, m0_wdata, m0_raddr, m1_waddr, m1_wdata, m1_raddr;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] s_rdata;

    // round-robin instance outputs
    logic [31:0] a_m0_rdata, a_m1_rdata, a_waddr, a_raddr, a_wdata;
    logic        a_m0_stall, a_m1_stall, a_wr, a_rd;
    logic [3:0]  a_wstrb;
    // fixed-priority instance outputs
    logic [31:0] b_m0_rdata, b_m1_rdata, b_waddr, b_raddr, b_wdata;
    logic        b_m0_stall, b_m1_stall, b_wr, b_rd;
    logic [3:0]  b_wstrb;

    always #5 clk = ~clk;

    bus_arbiter_2m #(.FIXED_PRIO(0), .LOCK_MAX(4)) dut_rr (
        .clk(clk), .rstn(rstn),
        .m0_wr(m0_wr), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rd(m0_rd), .m0_raddr(m0_raddr), .m0_rdata(a_m0_rdata), .m0_stall(a_m0_stall),
        .m1_wr(m1_wr), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rd(m1_rd), .m1_raddr(m1_raddr), .m1_rdata(a_m1_rdata), .m1_stall(a_m1_stall),
        .m1_lock(m1_lock),
        .s_wr(a_wr), .s_rd(a_rd), .s_waddr(a_waddr), .s_raddr(a_raddr),
        .s_wdata(a_wdata), .s_wstrb(a_wstrb), .s_rdata(s_rdata)
    );

    bus_arbiter_2m #(.FIXED_PRIO(1), .LOCK_MAX(4)) dut_fp (
        .clk(clk), .rstn(rstn),
        .m0_wr(m0_wr), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_rd(m0_rd), .m0_raddr(m0_raddr), .m0_rdata(b_m0_rdata), .m0_stall(b_m0_stall),
        .m1_wr(m1_wr), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_rd(m1_rd), .m1_raddr(m1_raddr), .m1_rdata(b_m1_rdata), .m1_stall(b_m1_stall),
        .m1_lock(m1_lock),
        .s_wr(b_wr), .s_rd(b_rd), .s_waddr(b_waddr), .s_raddr(b_raddr),
        .s_wdata(b_wdata), .s_wstrb(b_wstrb), .s_rdata(s_rdata)
    );

    typedef struct {
        string       tag;
        logic [1:0]  st_rr;
        logic        swr;
        logic        srd;
        logic [31:0] wa;
        logic [31:0] ra;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [1:0]  st_fp;
        logic        srd_fp;
        logic [31:0] ra_fp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, req);
        end
    endtask

    // Apply one cycle of stimulus; expected outputs built from the hand-computed
    // grant (0 none, 1 m0, 2 m1) for each instance and the hand-computed rdata.
    task automatic step(input string tag, input logic rv,
                        input logic w0, input logic r0, input logic w1, input logic r1,
                        input logic lk, input logic [31:0] srd,
                        input int g_rr, input int g_fp,
                        input logic [31:0] e_rd0, input logic [31:0] e_rd1);
        exp_t e;
        logic q0, q1;
        @(posedge clk);
        #1;
        rstn = rv; m0_wr = w0; m0_rd = r0; m1_wr = w1; m1_rd = r1; m1_lock = lk;
        s_rdata = srd;
        q0 = w0 | r0;
        q1 = w1 | r1;
        e.tag    = tag;
        e.st_rr  = !rv ? 2'b11 : {q1 && (g_rr != 2), q0 && (g_rr != 1)};
        e.st_fp  = !rv ? 2'b11 : {q1 && (g_fp != 2), q0 && (g_fp != 1)};
        e.swr    = (g_rr == 1) ? w0 : (g_rr == 2) ? w1 : 1'b0;
        e.srd    = (g_rr == 1) ? r0 : (g_rr == 2) ? r1 : 1'b0;
        e.wa     = (g_rr == 1) ? M0_WA : (g_rr == 2) ? M1_WA : 32'h0;
        e.ra     = (g_rr == 1) ? M0_RA : (g_rr == 2) ? M1_RA : 32'h0;
        e.wd     = (g_rr == 1) ? M0_WD : (g_rr == 2) ? M1_WD : 32'h0;
        e.ws     = (g_rr == 1) ? M0_WS : (g_rr == 2) ? M1_WS : 4'h0;
        e.srd_fp = (g_fp == 1) ? r0 : (g_fp == 2) ? r1 : 1'b0;
        e.ra_fp  = (g_fp == 1) ? M0_RA : (g_fp == 2) ? M1_RA : 32'h0;
        e.rd0    = e_rd0;
        e.rd1    = e_rd1;
        q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs mid-cycle against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "rr_stall", {30'd0, a_m1_stall, a_m0_stall}, {30'd0, e.st_rr});
                chk(e.tag, "rr_s_wr",  {31'd0, a_wr},   {31'd0, e.swr});
                chk(e.tag, "rr_s_rd",  {31'd0, a_rd},   {31'd0, e.srd});
                chk(e.tag, "rr_waddr", a_waddr, e.wa);
                chk(e.tag, "rr_raddr", a_raddr, e.ra);
                chk(e.tag, "rr_wdata", a_wdata, e.wd);
                chk(e.tag, "rr_wstrb", {28'd0, a_wstrb}, {28'd0, e.ws});
                chk(e.tag, "rr_m0_rdata", a_m0_rdata, e.rd0);
                chk(e.tag, "rr_m1_rdata", a_m1_rdata, e.rd1);
                chk(e.tag, "fp_stall", {30'd0, b_m1_stall, b_m0_stall}, {30'd0, e.st_fp});
                chk(e.tag, "fp_s_rd",  {31'd0, b_rd}, {31'd0, e.srd_fp});
                chk(e.tag, "fp_raddr", b_raddr, e.ra_fp);
            end
        end
    end

    initial begin
        rstn = 1'b0;
        m0_wr = 1'b0; m0_rd = 1'b1; m1_wr = 1'b0; m1_rd = 1'b1; m1_lock = 1'b0;
        m0_waddr = M0_WA; m0_wdata = M0_WD; m0_wstrb = M0_WS; m0_raddr = M0_RA;
        m1_waddr = M1_WA; m1_wdata = M1_WD; m1_wstrb = M1_WS; m1_raddr = M1_RA;
        s_rdata = 32'h0;

        //   tag      rstn w0 r0 w1 r1 lk  s_rdata        rr fp  m0_rdata      m1_rdata
        step("rst0",  0,   0, 1, 0, 1, 0, 32'h1234_5678, 0, 0, 32'h0,         32'h0);
        // contention after reset: RR alternates starting with m0, FP always m0
        step("A1",    1,   0, 1, 0, 1, 0, 32'h0000_00A1, 1, 1, 32'h0,         32'h0);
        step("A2",    1,   0, 1, 0, 1, 0, 32'h0000_00A2, 2, 1, 32'h0000_00A2, 32'h0);
        step("A3",    1,   0, 1, 0, 1, 0, 32'h0000_00A3, 1, 1, 32'h0,         32'h0000_00A3);
        step("A4",    1,   0, 1, 0, 1, 0, 32'h0000_00A4, 2, 1, 32'h0000_00A4, 32'h0);
        step("A5",    1,   0, 1, 0, 1, 0, 32'h0000_00A5, 1, 1, 32'h0,         32'h0000_00A5);
        step("A6",    1,   0, 1, 0, 1, 0, 32'h0000_00A6, 2, 1, 32'h0000_00A6, 32'h0);
        step("B1",    1,   0, 0, 0, 0, 0, 32'h0000_00B1, 0, 0, 32'h0,         32'h0000_00B1);
        // m0 write and read together, then the read returns
        step("B2",    1,   1, 1, 0, 0, 0, 32'h0BAD_F00D, 1, 1, 32'h0,         32'h0);
        step("B3",    1,   0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 32'h0);
        // m1 lock burst with LOCK_MAX=4: initial grant + 4 locked, then m0
        step("C1",    1,   0, 1, 0, 1, 1, 32'h0000_00C1, 2, 1, 32'h0,         32'h0);
        step("C2",    1,   0, 1, 0, 1, 1, 32'h0000_00C2, 2, 1, 32'h0,         32'h0000_00C2);
        step("C3",    1,   0, 1, 0, 1, 1, 32'h0000_00C3, 2, 1, 32'h0,         32'h0000_00C3);
        step("C4",    1,   0, 1, 0, 1, 1, 32'h0000_00C4, 2, 1, 32'h0,         32'h0000_00C4);
        step("C5",    1,   0, 1, 0, 1, 1, 32'h0000_00C5, 2, 1, 32'h0,         32'h0000_00C5);
        step("C6",    1,   0, 1, 0, 1, 1, 32'h0000_00C6, 1, 1, 32'h0,         32'h0000_00C6);
        // count cleared: m1 regains the grant and holds it again by lock
        step("C7",    1,   0, 1, 0, 1, 1, 32'h0000_00C7, 2, 1, 32'h0000_00C7, 32'h0);
        step("C8",    1,   0, 1, 0, 1, 1, 32'h0000_00C8, 2, 1, 32'h0,         32'h0000_00C8);
        step("D1",    1,   0, 0, 0, 0, 0, 32'h0000_00D1, 0, 0, 32'h0,         32'h0000_00D1);
        // m1 write only
        step("D2",    1,   0, 0, 1, 0, 0, 32'h0000_00D2, 2, 2, 32'h0,         32'h0);
        // m1 read accepted, then reset drops its return
        step("E1",    1,   0, 0, 0, 1, 0, 32'h0000_00E1, 2, 2, 32'h0,         32'h0);
        step("E2",    0,   0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 32'h0,         32'h0);
        step("E3",    1,   0, 1, 0, 1, 0, 32'h0000_00E3, 1, 1, 32'h0,         32'h0);
        step("E4",    1,   0, 0, 0, 0, 0, 32'h0000_0055, 0, 0, 32'h0000_0055, 32'h0);

        @(posedge clk);
        @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
